// File: rtl/rename_issue_ctrl_if.sv
// Bundle between rename_issue_ctrl and its neighbours (decoder, ROB head,
// rename register file).
//
// Handshake semantics: a decoded instruction transfers on a cycle where
// dec_valid && dec_ready are both high at the rising clock edge; dec_tag is
// the ROB tag that instruction receives. The decoder may hold or change its
// offer freely while dec_ready is low. Commit and flush are single-cycle
// requests with no back-pressure; the controller decides whether to act on
// them. rf_* outputs are strobes meaningful only in the cycle they are high.
//
// dbg_* signals expose the controller's internal state for checkers.
interface rename_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic              rdy;
  logic              dec_valid;
  logic              dec_has_rd;
  logic [4:0]        dec_rd;
  logic              dec_ready;
  logic [TAG_W-1:0]  dec_tag;
  logic              rob_commit_valid;
  logic [4:0]        rob_commit_rd;
  logic [31:0]       rob_commit_val;
  logic              flush_req;
  logic              rf_issue;
  logic [4:0]        rf_issue_rd;
  logic [TAG_W-1:0]  rf_issue_rob_pos;
  logic              rf_commit;
  logic [4:0]        rf_commit_rd;
  logic [31:0]       rf_commit_val;
  logic [TAG_W-1:0]  rf_commit_rob_pos;
  logic              rf_rollback;
  logic              rob_full;
  logic              dbg_state;
  logic [TAG_W:0]    dbg_count;
  logic [3:0]        dbg_flush_ctr;

  modport master (
    input  rdy, dec_valid, dec_has_rd, dec_rd,
           rob_commit_valid, rob_commit_rd, rob_commit_val, flush_req,
    output dec_ready, dec_tag,
           rf_issue, rf_issue_rd, rf_issue_rob_pos,
           rf_commit, rf_commit_rd, rf_commit_val, rf_commit_rob_pos,
           rf_rollback, rob_full,
           dbg_state, dbg_count, dbg_flush_ctr
  );

  modport slave (
    output rdy, dec_valid, dec_has_rd, dec_rd,
           rob_commit_valid, rob_commit_rd, rob_commit_val, flush_req,
    input  dec_ready, dec_tag,
           rf_issue, rf_issue_rd, rf_issue_rob_pos,
           rf_commit, rf_commit_rd, rf_commit_val, rf_commit_rob_pos,
           rf_rollback, rob_full,
           dbg_state, dbg_count, dbg_flush_ctr
  );
endinterface

// File: rtl/rename_issue_ctrl.sv
// rename_issue_ctrl: allocates ROB tags in order, drives rename register
// file issue/commit strobes, tracks ROB occupancy and sequences the
// mispredict rollback (one registered clear pulse, then FLUSH_CYCLES cycles
// with the decoder held off).
//
// Optional build macro RENAME_PERF_CNT_EN adds perf_stall / perf_flush
// counters as extra output ports.
module rename_issue_ctrl #(
  parameter int TAG_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  rename_issue_ctrl_if.master  bus
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_flush
`endif
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [TAG_W:0] DEPTH      = {1'b1, {TAG_W{1'b0}}};
  localparam logic [TAG_W:0] CNT_ONE    = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [3:0]     FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [3:0]       flush_ctr_q, flush_ctr_d;
  logic             rollback_q, rollback_d;

  logic run;
  logic full;
  logic dec_ready_w;
  logic accept;
  logic commit_acc;
  logic flush_take;

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
`endif

  // Handshake qualifiers; no commit bypass into dec_ready so a full ROB
  // stays full for the whole cycle even if the head retires.
  always_comb begin
    run         = (state_q == ST_RUN);
    full        = (count_q == DEPTH);
    dec_ready_w = bus.rdy & run & ~bus.flush_req & ~full;
    accept      = bus.dec_valid & dec_ready_w;
    commit_acc  = bus.rdy & bus.rob_commit_valid & (count_q != '0) & run;
    flush_take  = bus.rdy & run & bus.flush_req;
  end

  // Output strobes and pass-throughs; rdy low silences every strobe.
  always_comb begin
    bus.dec_ready         = dec_ready_w;
    bus.dec_tag           = tail_q;
    bus.rf_issue          = accept & bus.dec_has_rd & (bus.dec_rd != 5'd0);
    bus.rf_issue_rd       = bus.dec_rd;
    bus.rf_issue_rob_pos  = tail_q;
    bus.rf_commit         = commit_acc & (bus.rob_commit_rd != 5'd0);
    bus.rf_commit_rd      = bus.rob_commit_rd;
    bus.rf_commit_val     = bus.rob_commit_val;
    bus.rf_commit_rob_pos = head_q;
    bus.rf_rollback       = rollback_q & bus.rdy;
    bus.rob_full          = full;
    bus.dbg_state         = state_q;
    bus.dbg_count         = count_q;
    bus.dbg_flush_ctr     = flush_ctr_q;
  end

  // Next-state logic for the RUN/FLUSH sequencer and the ROB pointers.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flush_ctr_d = flush_ctr_q;
    rollback_d  = rollback_q;
    if (bus.rdy) begin
      rollback_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (bus.flush_req) begin
            // A commit in this cycle still strobes, but the pointers are
            // wiped anyway, so its head advance is irrelevant.
            state_d     = ST_FLUSH;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            flush_ctr_d = FLUSH_INIT;
            rollback_d  = 1'b1;
          end else begin
            if (accept)     tail_d = tail_q + 1'b1;
            if (commit_acc) head_d = head_q + 1'b1;
            case ({accept, commit_acc})
              2'b10:   count_d = count_q + CNT_ONE;
              2'b01:   count_d = count_q - CNT_ONE;
              default: count_d = count_q;
            endcase
          end
        end
        ST_FLUSH: begin
          if (flush_ctr_q <= 4'd1) begin
            state_d     = ST_RUN;
            flush_ctr_d = 4'd0;
          end else begin
            flush_ctr_d = flush_ctr_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State register; rst wins over rdy so a frozen flush can still be aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_ctr_q <= 4'd0;
      rollback_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_ctr_q <= flush_ctr_d;
      rollback_q  <= rollback_d;
    end
  end

`ifdef RENAME_PERF_CNT_EN
  // Stall cycles count only while enabled; flushes count when taken.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (bus.rdy & bus.dec_valid & ~dec_ready_w) perf_stall_d = perf_stall_q + 32'd1;
    if (flush_take)                             perf_flush_d = perf_flush_q + 32'd1;
  end

  // Performance counter registers, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  // Flush-taken qualifier only feeds the optional counters.
  logic unused_flush_take;
  assign unused_flush_take = flush_take;
`endif

endmodule

// File: tb/tb_rename_issue_ctrl.sv
// Testbench for rename_issue_ctrl: directed steps followed by randomized
// traffic, every cycle compared against a queue-based ROB model.
module tb_rename_issue_ctrl;

  localparam int TAG_W        = 4;
  localparam int DEPTH        = 16;
  localparam int FLUSH_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rename_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  rename_issue_ctrl #(
    .TAG_W        (TAG_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RENAME_PERF_CNT_EN
    ,
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  // ---------------- reference model state ----------------
  int q_tags[$];     // tags of in-flight instructions, oldest first
  int m_tail;        // next tag to hand out
  int m_flush;       // remaining flush cycles, 0 = running
  bit m_rb;          // rollback pulse pending
  int m_stall;
  int m_flushes;
  bit chk_en;

  int tests;
  int fails;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance it.
  task automatic cyc();
    int  sz;
    int  head;
    bit  run;
    bit  full;
    bit  rdy_e;
    bit  acc;
    bit  cacc;
    #3;
    sz    = q_tags.size();
    run   = (m_flush == 0);
    full  = (sz == DEPTH);
    rdy_e = bus.rdy && run && !bus.flush_req && !full;
    acc   = bus.dec_valid && rdy_e;
    cacc  = bus.rdy && bus.rob_commit_valid && (sz != 0) && run;
    head  = (sz != 0) ? q_tags[0] : m_tail;
    if (chk_en) begin
      chk("dec_ready",   32'(bus.dec_ready),         32'(rdy_e));
      chk("dec_tag",     32'(bus.dec_tag),           32'(m_tail));
      chk("rf_issue",    32'(bus.rf_issue),          32'(acc && bus.dec_has_rd && bus.dec_rd != 5'd0));
      chk("issue_pos",   32'(bus.rf_issue_rob_pos),  32'(m_tail));
      chk("issue_rd",    32'(bus.rf_issue_rd),       32'(bus.dec_rd));
      chk("rf_commit",   32'(bus.rf_commit),         32'(cacc && bus.rob_commit_rd != 5'd0));
      chk("commit_pos",  32'(bus.rf_commit_rob_pos), 32'(head));
      chk("commit_rd",   32'(bus.rf_commit_rd),      32'(bus.rob_commit_rd));
      chk("commit_val",  bus.rf_commit_val,          bus.rob_commit_val);
      chk("rf_rollback", 32'(bus.rf_rollback),       32'(bus.rdy && m_rb));
      chk("rob_full",    32'(bus.rob_full),          32'(full));
      chk("count",       32'(bus.dbg_count),         32'(sz));
      chk("flush_ctr",   32'(bus.dbg_flush_ctr),     32'(m_flush));
      chk("state",       32'(bus.dbg_state),         32'(!run));
`ifdef RENAME_PERF_CNT_EN
      chk("perf_stall",  perf_stall,                 32'(m_stall));
      chk("perf_flush",  perf_flush,                 32'(m_flushes));
`endif
    end
    @(posedge clk);
    if (rst) begin
      q_tags.delete();
      m_tail    = 0;
      m_flush   = 0;
      m_rb      = 1'b0;
      m_stall   = 0;
      m_flushes = 0;
    end else if (bus.rdy) begin
      if (bus.dec_valid && !rdy_e) m_stall++;
      m_rb = 1'b0;
      if (run) begin
        if (bus.flush_req) begin
          q_tags.delete();
          m_tail  = 0;
          m_flush = FLUSH_CYCLES;
          m_rb    = 1'b1;
          m_flushes++;
        end else begin
          if (cacc) void'(q_tags.pop_front());
          if (acc) begin
            q_tags.push_back(m_tail);
            m_tail = (m_tail + 1) % DEPTH;
          end
        end
      end else begin
        m_flush--;
      end
    end
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    bus.rdy              = 1'b1;
    bus.dec_valid        = 1'b0;
    bus.dec_has_rd       = 1'b0;
    bus.dec_rd           = 5'd0;
    bus.rob_commit_valid = 1'b0;
    bus.rob_commit_rd    = 5'd0;
    bus.rob_commit_val   = 32'd0;
    bus.flush_req        = 1'b0;
  endtask

  task automatic drive_issue(input logic has_rd, input logic [4:0] rd);
    bus.dec_valid  = 1'b1;
    bus.dec_has_rd = has_rd;
    bus.dec_rd     = rd;
  endtask

  task automatic drive_commit(input logic [4:0] rd, input logic [31:0] val);
    bus.rob_commit_valid = 1'b1;
    bus.rob_commit_rd    = rd;
    bus.rob_commit_val   = val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    q_tags.delete();
    m_tail = 0; m_flush = 0; m_rb = 1'b0; m_stall = 0; m_flushes = 0;

    // Reset
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("reset_dec_ready", 32'(bus.dec_ready), 32'd1);
    chk("reset_rollback",  32'(bus.rf_rollback), 32'd0);
    chk("reset_tag",       32'(bus.dec_tag), 32'd0);

    // Issue rd=5: strobe at tag 0, then tag 1 and count 1
    drive_issue(1'b1, 5'd5);
    cyc();
    chk("first_tag", 32'(bus.dec_tag), 32'd1);
    chk("first_cnt", 32'(bus.dbg_count), 32'd1);

    // Fill the ROB to 16
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive_issue(1'b1, 5'(i + 1));
      cyc();
    end
    chk("full_flag",  32'(bus.rob_full), 32'd1);
    chk("full_ready", 32'(bus.dec_ready), 32'd0);
    cyc();

    // Full ROB: commit rd=3 together with an offer -> commit only
    drive_commit(5'd3, 32'hDEAD_0003);
    cyc();
    bus.rob_commit_valid = 1'b0;
    chk("after_commit_cnt",   32'(bus.dbg_count), 32'd15);
    chk("after_commit_ready", 32'(bus.dec_ready), 32'd1);
    cyc();
    chk("refill_cnt", 32'(bus.dbg_count), 32'd16);

    // Make room, then issue without a real destination
    bus.dec_valid = 1'b0;
    drive_commit(5'd7, 32'h0000_1234);
    cyc();
    cyc();
    bus.rob_commit_valid = 1'b0;
    drive_issue(1'b0, 5'd9);
    cyc();
    drive_issue(1'b1, 5'd0);
    cyc();
    chk("nord_tag", 32'(bus.dec_tag), 32'(m_tail));

    // Drain to 3 in flight, then flush with a same-cycle commit
    bus.dec_valid = 1'b0;
    drive_commit(5'd4, 32'h4444_0000);
    for (int i = 0; i < DEPTH; i++) begin
      if (q_tags.size() > 3) cyc();
    end
    chk("three_cnt", 32'(bus.dbg_count), 32'd3);
    drive_commit(5'd9, 32'h9999_0009);
    bus.flush_req = 1'b1;
    drive_issue(1'b1, 5'd6);
    cyc();
    bus.flush_req        = 1'b0;
    bus.rob_commit_valid = 1'b0;
    chk("rb_pulse", 32'(bus.rf_rollback), 32'd1);
    chk("rb_tag",   32'(bus.dec_tag), 32'd0);
    chk("rb_ready", 32'(bus.dec_ready), 32'd0);
    cyc();
    chk("rb_drop",  32'(bus.rf_rollback), 32'd0);
    chk("fl_ready", 32'(bus.dec_ready), 32'd0);
    cyc();
    chk("resume_ready", 32'(bus.dec_ready), 32'd1);
    cyc();

    // Flush, then freeze with rdy=0 in the second flush cycle
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    cyc();
    bus.rdy = 1'b0;
    drive_commit(5'd2, 32'h2222_2222);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("frozen_ctr", 32'(bus.dbg_flush_ctr), 32'd1);
    end
    bus.rdy = 1'b1;
    bus.rob_commit_valid = 1'b0;
    cyc();
    chk("thaw_state", 32'(bus.dbg_state), 32'd0);

    // Reset in the middle of a flush
    drive_issue(1'b1, 5'd8);
    cyc();
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_fl_state", 32'(bus.dbg_state), 32'd0);
    chk("rst_fl_count", 32'(bus.dbg_count), 32'd0);
    chk("rst_fl_rb",    32'(bus.rf_rollback), 32'd0);

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 800; i++) begin
      bus.rdy              = ($urandom_range(0, 9) != 0);
      rst                  = ($urandom_range(0, 199) == 0);
      bus.dec_valid        = ($urandom_range(0, 9) < 7);
      bus.dec_has_rd       = ($urandom_range(0, 4) != 0);
      bus.dec_rd           = 5'($urandom_range(0, 31));
      bus.rob_commit_valid = ($urandom_range(0, 9) < ((i % 200) < 100 ? 2 : 7));
      bus.rob_commit_rd    = 5'($urandom_range(0, 31));
      bus.rob_commit_val   = $urandom;
      bus.flush_req        = ($urandom_range(0, 39) == 0);
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
